// File: rtl/spi_reg_bank_if.sv
// SPI pin bundle between an external controller (master) and spi_reg_bank (slave).
interface spi_reg_bank_if;
   logic sclk;
   logic cs_n;
   logic copi;
   logic cipo;
   logic cipo_oe;

   modport master (output sclk, cs_n, copi, input cipo, cipo_oe);
   modport slave  (input sclk, cs_n, copi, output cipo, cipo_oe);
endinterface

// File: rtl/spi_reg_bank.sv
// Oversampled SPI mode-0 register bank with length-checked frames and a write strobe.
// Define SPI_REG_READBACK_EN to build the cipo readback shifter; otherwise cipo/cipo_oe are tied low.
module spi_reg_bank #(
   parameter int NUM_REGS = 5,
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 7
) (
   input  logic                         clk,
   input  logic                         rst_n,
   spi_reg_bank_if.slave                spi,
   output logic [NUM_REGS*DATA_W-1:0]   regs,
   output logic                         wr_strobe,
   output logic [ADDR_W-1:0]            wr_addr,
   output logic                         frame_err
);

   localparam int FRAME_W = 1 + ADDR_W + DATA_W;
   localparam int CNT_W   = $clog2(FRAME_W + 1);
   localparam logic [CNT_W-1:0] CNT_CMD_END = CNT_W'(1 + ADDR_W);
   localparam logic [CNT_W-1:0] CNT_FRAME   = CNT_W'(FRAME_W);
   localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(FRAME_W + 1);

   typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_WAIT} state_t;

   state_t              state, state_nxt;
   logic [2:0]          sclk_sync, cs_sync;
   logic [1:0]          copi_sync;
   logic [CNT_W-1:0]    cnt;
   logic [FRAME_W-1:0]  rx;
   logic                addr_ok;

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   // cs_n syncs reset to its idle (high) level so releasing reset never fakes a chip-select edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync <= '0;
         cs_sync   <= '1;
         copi_sync <= '0;
      end else begin
         sclk_sync <= {sclk_sync[1:0], spi.sclk};
         cs_sync   <= {cs_sync[1:0], spi.cs_n};
         copi_sync <= {copi_sync[0], spi.copi};
      end
   end

   wire sclk_rise = sclk_sync[1] & ~sclk_sync[2];
   wire cs_fall   = ~cs_sync[1] & cs_sync[2];
   wire cs_rise   = cs_sync[1] & ~cs_sync[2];
   wire cs_low    = ~cs_sync[1];

   wire                rx_rw   = rx[FRAME_W-1];
   wire [ADDR_W-1:0]   rx_addr = rx[FRAME_W-2 -: ADDR_W];
   wire [DATA_W-1:0]   rx_data = rx[DATA_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: if (cs_fall) state_nxt = S_CMD;
         S_CMD:  if (cnt == CNT_CMD_END) state_nxt = S_DATA;
         S_DATA: if (cnt == CNT_FRAME) state_nxt = S_WAIT;
         S_WAIT: state_nxt = S_WAIT;
         default: state_nxt = S_IDLE;
      endcase
      if (cs_rise)                         state_nxt = S_IDLE;
      else if (cs_fall && state != S_IDLE) state_nxt = S_CMD;
   end

   // Counter saturates one past a full frame so over-long frames stay distinguishable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         rx  <= '0;
      end else if (cs_fall || cs_rise) begin
         cnt <= '0;
      end else if (sclk_rise && cs_low && state != S_IDLE) begin
         rx <= {rx[FRAME_W-2:0], copi_sync[1]};
         if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      end
   end

   always_comb begin
      addr_ok = 1'b0;
      for (int k = 0; k < NUM_REGS; k++)
         if (rx_addr == ADDR_W'(k)) addr_ok = 1'b1;
   end

   // NOTE: the bank is small and directly visible on the outputs, so every register is reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs      <= '0;
         wr_strobe <= 1'b0;
         wr_addr   <= '0;
         frame_err <= 1'b0;
      end else begin
         wr_strobe <= 1'b0;
         frame_err <= 1'b0;
         if (cs_rise) begin
            if (cnt == CNT_FRAME) begin
               if (rx_rw && addr_ok) begin
                  for (int k = 0; k < NUM_REGS; k++)
                     if (rx_addr == ADDR_W'(k)) regs[k*DATA_W +: DATA_W] <= rx_data;
                  wr_strobe <= 1'b1;
                  wr_addr   <= rx_addr;
               end
            end else if (cnt != '0) begin
               frame_err <= 1'b1;
            end
         end
      end
   end

`ifdef SPI_REG_READBACK_EN
   logic [DATA_W-1:0] tx_sr, rd_word;
   logic              cipo_q;
   wire               sclk_fall = ~sclk_sync[1] & sclk_sync[2];

   // Address bits sit at the bottom of rx right after the last address bit arrives.
   always_comb begin
      rd_word = '0;
      for (int k = 0; k < NUM_REGS; k++)
         if (rx[ADDR_W-1:0] == ADDR_W'(k)) rd_word = regs[k*DATA_W +: DATA_W];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_sr  <= '0;
         cipo_q <= 1'b0;
      end else if (state == S_IDLE) begin
         cipo_q <= 1'b0;
      end else if (state == S_CMD && cnt == CNT_CMD_END) begin
         tx_sr <= rd_word;
      end else if (sclk_fall && state inside {S_DATA, S_WAIT}) begin
         cipo_q <= tx_sr[DATA_W-1];
         tx_sr  <= {tx_sr[DATA_W-2:0], 1'b0};
      end
   end

   assign spi.cipo_oe = cs_low;
   assign spi.cipo    = cipo_q & cs_low;
`else
   assign spi.cipo_oe = 1'b0;
   assign spi.cipo    = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed plus randomized frames for spi_reg_bank against a frame-level register model.
module tb_spi_reg_bank;
   localparam int NUM_REGS = 5;
   localparam int DATA_W   = 8;
   localparam int ADDR_W   = 7;
   localparam int FRAME_W  = 1 + ADDR_W + DATA_W;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   spi_reg_bank_if bus ();
   logic [NUM_REGS*DATA_W-1:0] regs;
   logic                       wr_strobe, frame_err;
   logic [ADDR_W-1:0]          wr_addr;

   spi_reg_bank #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .spi       (bus.slave),
      .regs      (regs),
      .wr_strobe (wr_strobe),
      .wr_addr   (wr_addr),
      .frame_err (frame_err)
   );

   int checks   = 0;
   int failures = 0;
   int strobe_cnt = 0;
   int err_cnt    = 0;
   logic overlap_seen = 1'b0;

   logic [DATA_W-1:0]          model_regs [NUM_REGS];
   logic [ADDR_W-1:0]          model_wr_addr;
   logic [NUM_REGS*DATA_W-1:0] lat_pre, lat_post;
   logic                       lat_pre_stb, lat_stb;
   logic [DATA_W-1:0]          rd_bits;
   logic                       oe_mid;

   // Pulse monitor: a pulse wider than one cycle shows up as an extra count.
   always @(negedge clk) begin
      if (wr_strobe) strobe_cnt++;
      if (frame_err) err_cnt++;
      if (wr_strobe && frame_err) overlap_seen = 1'b1;
   end

   initial begin
      #600_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NUM_REGS*DATA_W-1:0] model_flat();
      logic [NUM_REGS*DATA_W-1:0] f;
      for (int k = 0; k < NUM_REGS; k++) f[k*DATA_W +: DATA_W] = model_regs[k];
      return f;
   endfunction

   // Frame semantics: only an exact-length write to a legal address changes state.
   task automatic model_frame(input logic [31:0] v, input int n, output int exp_stb, output int exp_err);
      logic [15:0] f;
      f = v[31:16];
      exp_stb = 0;
      exp_err = 0;
      if (n == FRAME_W) begin
         if (f[15] == 1'b1 && int'(f[14:8]) < NUM_REGS) begin
            model_regs[int'(f[14:8])] = f[7:0];
            model_wr_addr = f[14:8];
            exp_stb = 1;
         end
      end else if (n != 0) begin
         exp_err = 1;
      end
   endtask

   task automatic cs_start();
      bus.cs_n = 1'b0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   // Sends the top n bits of v MSB first; cipo is sampled just before each data-bit rise.
   task automatic send_bits(input logic [31:0] v, input int n);
      for (int i = 0; i < n; i++) begin
         bus.copi = v[31-i];
         repeat (8) @(posedge clk);
         #1;
         if (i >= 1 + ADDR_W && i < FRAME_W) rd_bits[FRAME_W-1-i] = bus.cipo;
         if (i == 1 + ADDR_W) oe_mid = bus.cipo_oe;
         bus.sclk = 1'b1;
         repeat (8) @(posedge clk);
         #1;
         bus.sclk = 1'b0;
      end
   endtask

   // Raises cs_n just after an edge and snapshots outputs after the 2nd and 3rd edges.
   task automatic cs_end();
      repeat (4) @(posedge clk);
      #1;
      bus.cs_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      lat_pre     = regs;
      lat_pre_stb = wr_strobe;
      @(posedge clk);
      #1;
      lat_post = regs;
      lat_stb  = wr_strobe;
      repeat (6) @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input string tag, input logic [31:0] v, input int n);
      int s0, e0, exp_stb, exp_err;
      logic [NUM_REGS*DATA_W-1:0] pre_flat;
      s0 = strobe_cnt;
      e0 = err_cnt;
      pre_flat = model_flat();
      model_frame(v, n, exp_stb, exp_err);
      cs_start();
      send_bits(v, n);
      cs_end();
      chk({tag, "_lat_pre"},  lat_pre, pre_flat);
      chk({tag, "_lat_stb0"}, lat_pre_stb, 0);
      chk({tag, "_lat_post"}, lat_post, model_flat());
      chk({tag, "_lat_stb"},  lat_stb, exp_stb);
      chk({tag, "_regs"},     regs, model_flat());
      chk({tag, "_strobes"},  strobe_cnt - s0, exp_stb);
      chk({tag, "_errs"},     err_cnt - e0, exp_err);
      chk({tag, "_wr_addr"},  wr_addr, model_wr_addr);
   endtask

   int          s_base, e_base, d_stb, d_err, rn;
   logic        r_rw;
   logic [6:0]  r_addr;
   logic [7:0]  r_data;
   logic [15:0] r_tail;

   initial begin
      rst_n    = 1'b0;
      bus.sclk = 1'b0;
      bus.cs_n = 1'b1;
      bus.copi = 1'b0;
      rd_bits  = 'x;
      oe_mid   = 1'b0;
      for (int k = 0; k < NUM_REGS; k++) model_regs[k] = '0;
      model_wr_addr = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_regs", regs, 0);
      chk("rst_strobe", wr_strobe, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_frame_err", frame_err, 0);
      chk("rst_cipo", bus.cipo, 0);
      chk("rst_cipo_oe", bus.cipo_oe, 0);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      run_frame("wr81A5", {16'h81A5, 16'h0000}, 16);
      chk("wr81A5_reg1", regs[1*DATA_W +: DATA_W], 8'hA5);
      run_frame("wr8733", {16'h8733, 16'h0000}, 16);
      run_frame("len10",  {16'h8123, 16'h0000}, 10);
      run_frame("len17",  {16'h8455, 16'h8000}, 17);
      chk("len17_reg4", regs[4*DATA_W +: DATA_W], 8'h00);

      run_frame("rd0100", {16'h0100, 16'h0000}, 16);
`ifdef SPI_REG_READBACK_EN
      chk("rd0100_cipo_bits", rd_bits, 8'hA5);
      chk("rd0100_oe_mid", oe_mid, 1);
`else
      chk("rd0100_cipo_bits", rd_bits, 8'h00);
      chk("rd0100_oe_mid", oe_mid, 0);
`endif
      chk("rd0100_oe_after", bus.cipo_oe, 0);
      chk("rd0100_cipo_after", bus.cipo, 0);

      run_frame("cs_pulse", 32'h0, 0);

      // Reset mid-frame: abort with no commit and no pulses.
      s_base = strobe_cnt;
      e_base = err_cnt;
      cs_start();
      send_bits({16'h8266, 16'h0000}, 9);
      rst_n    = 1'b0;
      bus.cs_n = 1'b1;
      for (int k = 0; k < NUM_REGS; k++) model_regs[k] = '0;
      model_wr_addr = '0;
      repeat (4) @(posedge clk);
      #1;
      chk("midrst_regs", regs, 0);
      chk("midrst_wr_addr", wr_addr, 0);
      chk("midrst_cipo_oe", bus.cipo_oe, 0);
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("midrst_no_strobe", strobe_cnt - s_base, 0);
      chk("midrst_no_err", err_cnt - e_base, 0);
      run_frame("wr8266", {16'h8266, 16'h0000}, 16);
      chk("wr8266_reg2", regs[2*DATA_W +: DATA_W], 8'h66);

      // Back-to-back frames separated by a 2-clk chip-select gap.
      s_base = strobe_cnt;
      e_base = err_cnt;
      model_frame({16'h8011, 16'h0000}, 16, d_stb, d_err);
      model_frame({16'h8322, 16'h0000}, 16, d_stb, d_err);
      cs_start();
      send_bits({16'h8011, 16'h0000}, 16);
      repeat (4) @(posedge clk);
      #1;
      bus.cs_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      bus.cs_n = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      send_bits({16'h8322, 16'h0000}, 16);
      cs_end();
      chk("b2b_reg0", regs[0*DATA_W +: DATA_W], 8'h11);
      chk("b2b_reg3", regs[3*DATA_W +: DATA_W], 8'h22);
      chk("b2b_regs", regs, model_flat());
      chk("b2b_strobes", strobe_cnt - s_base, 2);
      chk("b2b_errs", err_cnt - e_base, 0);
      chk("b2b_wr_addr", wr_addr, 3);

      for (int t = 0; t < 20; t++) begin
         r_rw   = 1'($urandom_range(0, 1));
         r_addr = 7'($urandom_range(0, 7));
         r_data = 8'($urandom);
         r_tail = 16'($urandom);
         rn     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : FRAME_W;
         run_frame($sformatf("rnd%0d", t), {r_rw, r_addr, r_data, r_tail}, rn);
      end

      chk("no_strobe_err_overlap", overlap_seen, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
